// File: rtl/dut_vector_sequencer_if.sv
// Memory-side bus of the vector sequencer: vector/expected read port and
// result write port. The sequencer is the master; the memories are the slave.
interface dut_vector_sequencer_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] vec_raddr;
    logic [BUS_WIDTH-1:0]  vec_rdata;
    logic [BUS_WIDTH-1:0]  exp_rdata;
    logic                  res_we;
    logic [ADDR_WIDTH-1:0] res_waddr;
    logic [BUS_WIDTH-1:0]  res_wdata;

    modport master (
        output vec_raddr,
        input  vec_rdata,
        input  exp_rdata,
        output res_we,
        output res_waddr,
        output res_wdata
    );

    modport slave (
        input  vec_raddr,
        output vec_rdata,
        output exp_rdata,
        input  res_we,
        input  res_waddr,
        input  res_wdata
    );
endinterface

// File: rtl/dut_vector_sequencer.sv
// Tester vector sequencer: fetches vectors from memory, drives them onto the
// pads, waits a programmable settle time, samples the pads and writes the
// sampled values to result memory. Per-vector period is settle_cycles+3.
// Optional compare logic is enabled by defining DUT_VECTOR_COMPARE_EN; when
// undefined, the mismatch outputs are tied to zero and exp_rdata is ignored.
module dut_vector_sequencer #(
    parameter int  BUS_WIDTH    = 32,
    parameter int  DEPTH        = 256,
    parameter int  SETTLE_WIDTH = 8,
    localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    go,
    input  logic [BUS_WIDTH-1:0]    dir_mask,
    input  logic [ADDR_WIDTH:0]     burst_len,
    input  logic [SETTLE_WIDTH-1:0] settle_cycles,
    dut_vector_sequencer_if.master  mem,
    output logic [BUS_WIDTH-1:0]    pad_o,
    output logic [BUS_WIDTH-1:0]    pad_oe,
    input  logic [BUS_WIDTH-1:0]    pad_i,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             mismatch_cnt,
    output logic [ADDR_WIDTH-1:0]   first_fail_idx,
    output logic                    first_fail_valid
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BUS_WIDTH-1:0]    mask_q;
    logic [SETTLE_WIDTH-1:0] settle_q;
    logic [SETTLE_WIDTH-1:0] settle_cnt;
    logic [ADDR_WIDTH:0]     burst_q;
    logic [ADDR_WIDTH:0]     burst_clamped;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    last_vec;

    assign burst_clamped = (burst_len > DEPTH_LEN) ? DEPTH_LEN : burst_len;
    assign last_vec      = ({1'b0, idx} == (burst_q - 1'b1));
    assign mem.vec_raddr = idx;
    assign mem.res_waddr = idx;

    // State register; reset always returns the sequencer to IDLE.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state outputs; dropping go in any busy state aborts.
    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        pad_oe        = '0;
        mem.res_we    = 1'b0;
        mem.res_wdata = '0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_next = (burst_clamped == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                pad_oe     = (idx != '0) ? mask_q : '0;
                state_next = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                pad_oe     = mask_q;
                state_next = (settle_q == '0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                busy   = 1'b1;
                pad_oe = mask_q;
                if (settle_cnt == SETTLE_WIDTH'(1)) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy          = 1'b1;
                pad_oe        = mask_q;
                mem.res_we    = go;
                mem.res_wdata = pad_i;
                state_next    = last_vec ? DONE : FETCH;
            end
            DONE: begin
                done = 1'b1;
                if (!go) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (busy && !go) begin
            state_next = IDLE;
        end
    end

    // Run settings are latched at start; vector index, drive data and settle timer.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mask_q     <= '0;
            settle_q   <= '0;
            burst_q    <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            pad_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        mask_q   <= dir_mask;
                        settle_q <= settle_cycles;
                        burst_q  <= burst_clamped;
                        idx      <= '0;
                    end
                end
                LOAD: begin
                    pad_o      <= mem.vec_rdata;
                    settle_cnt <= settle_q;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
                SAMPLE: begin
                    if (go && !last_vec) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DUT_VECTOR_COMPARE_EN
    logic [BUS_WIDTH-1:0] exp_q;
    logic                 fail_now;

    assign fail_now = ((pad_i ^ exp_q) & ~mask_q) != '0;

    // Expected data is captured with the vector; sampled-pin differences are counted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            exp_q            <= '0;
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            if (state == IDLE && go) begin
                mismatch_cnt     <= '0;
                first_fail_idx   <= '0;
                first_fail_valid <= 1'b0;
            end
            if (state == LOAD) begin
                exp_q <= mem.exp_rdata;
            end
            if (mem.res_we && fail_now) begin
                if (mismatch_cnt != 16'hFFFF) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                if (!first_fail_valid) begin
                    first_fail_idx   <= idx;
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic [BUS_WIDTH-1:0] unused_exp;

    assign unused_exp       = mem.exp_rdata;
    assign mismatch_cnt     = '0;
    assign first_fail_idx   = '0;
    assign first_fail_valid = 1'b0;
`endif

endmodule
